// File: rtl/gpio_pattern_pkg.sv
// Shared types and helpers for the GPIO pattern generator: pattern modes,
// request mapping and per-mode frame lengths.
package gpio_pattern_pkg;

    typedef enum logic [2:0] {
        WALK1  = 3'd0,
        WALK0  = 3'd1,
        COUNT  = 3'd2,
        TOGGLE = 3'd3,
        PIN_ID = 3'd4
    } pattern_mode_t;

    localparam int unsigned COUNT_FRAME_LEN = 256;

    // Unassigned encodings fall back to walk-one so the pins never go undefined.
    function automatic pattern_mode_t map_mode(input logic [2:0] req);
        pattern_mode_t result;
        if (req > 3'd4) begin
            result = WALK1;
        end else begin
            result = pattern_mode_t'(req);
        end
        return result;
    endfunction

    function automatic int unsigned frame_len(input pattern_mode_t mode,
                                              input int unsigned num_pins,
                                              input int unsigned gap);
        int unsigned len;
        case (mode)
            WALK1, WALK0: len = num_pins;
            COUNT:        len = COUNT_FRAME_LEN;
            TOGGLE:       len = 2;
            default:      len = 2 * num_pins + gap;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/gpio_step_prescaler.sv
// Divides the design clock down to one step tick every DIV clocks while running.
module gpio_step_prescaler #(
    parameter int unsigned DIV = 12_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = run && (count == CNT_W'(DIV - 1));

    // Held at zero whenever not running so every new run starts a full step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gpio_pattern_gen.sv
// GPIO exerciser: steps one of five test patterns across NUM_PINS outputs at
// STEP_HZ, switching mode only on frame boundaries.
module gpio_pattern_gen
    import gpio_pattern_pkg::*;
#(
    parameter int unsigned NUM_PINS  = 32,
    parameter int unsigned CLOCK_HZ  = 12_000_000,
    parameter int unsigned STEP_HZ   = 1_000,
    parameter int unsigned GAP_STEPS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [2:0]          mode,
    output logic [NUM_PINS-1:0] pins,
    output logic                frame_start,
    output logic [2:0]          cur_mode
);

    localparam int unsigned DIV        = (STEP_HZ == 0) ? 0 : CLOCK_HZ / STEP_HZ;
    localparam int unsigned PIN_ID_LEN = 2 * NUM_PINS + GAP_STEPS;
    localparam int unsigned MAX_FRAME  = (PIN_ID_LEN > COUNT_FRAME_LEN) ? PIN_ID_LEN : COUNT_FRAME_LEN;
    localparam int unsigned STEP_W     = $clog2(MAX_FRAME) + 1;
    localparam int unsigned HALF_W     = STEP_W - 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (NUM_PINS < 2 || NUM_PINS > 64) begin : g_bad_num_pins
        $error("gpio_pattern_gen: NUM_PINS must be in 2..64");
    end
    if (DIV < 1) begin : g_bad_div
        $error("gpio_pattern_gen: CLOCK_HZ / STEP_HZ must be at least 1");
    end
    if (GAP_STEPS < 1) begin : g_bad_gap
        $error("gpio_pattern_gen: GAP_STEPS must be at least 1");
    end

    logic [0:0]          state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [NUM_PINS-1:0] counter_q, counter_d;
    pattern_mode_t       cur_mode_q, cur_mode_d, req_mode;
    logic                frame_start_q, frame_start_d;
    logic [NUM_PINS-1:0] pins_q, pattern;
    logic                run, tick, last_step;

    // Gating with en makes a drop of en on the wrap tick win over the wrap.
    assign run = (state_q == ST_RUN) && en;

    gpio_step_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Next-state logic; pins are decoded from these values so the output
    // register lines up with the step that is about to be in effect.
    always_comb begin
        req_mode      = map_mode(mode);
        last_step     = (step_q == STEP_W'(frame_len(cur_mode_q, NUM_PINS, GAP_STEPS) - 1));
        state_d       = state_q;
        step_d        = step_q;
        counter_d     = counter_q;
        cur_mode_d    = cur_mode_q;
        frame_start_d = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            step_d     = '0;
            counter_d  = '0;
            cur_mode_d = req_mode;
        end else if (state_q == ST_IDLE) begin
            state_d       = ST_RUN;
            step_d        = '0;
            counter_d     = '0;
            cur_mode_d    = req_mode;
            frame_start_d = 1'b1;
        end else if (tick) begin
            counter_d = counter_q + 1'b1;
            if (last_step) begin
                step_d        = '0;
                cur_mode_d    = req_mode;
                frame_start_d = 1'b1;
                if (req_mode != cur_mode_q) begin
                    counter_d = '0;
                end
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_comb begin
        pattern = '0;
        case (cur_mode_d)
            WALK1: begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    pattern[i] = (step_d == STEP_W'(i));
                end
            end
            WALK0: begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    pattern[i] = (step_d != STEP_W'(i));
                end
            end
            COUNT:  pattern = counter_d;
            TOGGLE: pattern = (step_d == '0) ? '1 : '0;
            PIN_ID: begin
                // Pin i is high on even steps while step/2 <= i; gap steps exceed every i.
                for (int i = 0; i < NUM_PINS; i++) begin
                    pattern[i] = !step_d[0] && (step_d[STEP_W-1:1] <= HALF_W'(i));
                end
            end
            default: pattern = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            counter_q     <= '0;
            cur_mode_q    <= WALK1;
            frame_start_q <= 1'b0;
            pins_q        <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            counter_q     <= counter_d;
            cur_mode_q    <= cur_mode_d;
            frame_start_q <= frame_start_d;
            pins_q        <= (state_d == ST_RUN) ? pattern : '0;
        end
    end

    assign pins        = pins_q;
    assign frame_start = frame_start_q;
    assign cur_mode    = cur_mode_q;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed bench for gpio_pattern_gen: a DIV=3 instance for the pattern
// sequences and a DIV=1 instance for the long count frame.
module tb_gpio_pattern_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [3:0] pins;
    logic       frame_start;
    logic [2:0] cur_mode;

    logic       en_fast;
    logic [2:0] mode_fast;
    logic [3:0] pins_fast;
    logic       frame_start_fast;
    logic [2:0] cur_mode_fast;

    int test_count;
    int fail_count;

    gpio_pattern_gen #(
        .NUM_PINS  (4),
        .CLOCK_HZ  (3),
        .STEP_HZ   (1),
        .GAP_STEPS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .pins        (pins),
        .frame_start (frame_start),
        .cur_mode    (cur_mode)
    );

    gpio_pattern_gen #(
        .NUM_PINS  (4),
        .CLOCK_HZ  (1),
        .STEP_HZ   (1),
        .GAP_STEPS (2)
    ) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .en          (en_fast),
        .mode        (mode_fast),
        .pins        (pins_fast),
        .frame_start (frame_start_fast),
        .cur_mode    (cur_mode_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n active edges and settle just after the last one.
    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en_v, input logic [2:0] mode_v, input int clocks);
        en   = en_v;
        mode = mode_v;
        waitClocks(clocks);
    endtask

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] walk1_exp [13];
        logic [3:0] pin_id_exp [10];
        int pulses_pin3;
        int pulses_pin0;

        walk1_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                       4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        pin_id_exp = '{4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b1100,
                       4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

        test_count = 0;
        fail_count = 0;
        reset      = 1'b1;
        en         = 1'b0;
        mode       = 3'd0;
        en_fast    = 1'b0;
        mode_fast  = 3'd0;

        waitClocks(2);
        checkOutput("reset pins", 64'(pins), 64'h0);
        checkOutput("reset frame_start", 64'(frame_start), 64'h0);
        checkOutput("reset cur_mode", 64'(cur_mode), 64'h0);
        reset = 1'b0;
        waitClocks(1);
        checkOutput("idle pins", 64'(pins), 64'h0);

        // Walk-one: each step held 3 clocks, frame_start every 12 clocks.
        applyStimulus(1'b1, 3'd0, 1);
        for (int c = 0; c < 13; c++) begin
            checkOutput($sformatf("walk1 pins c%0d", c), 64'(pins), 64'(walk1_exp[c]));
            checkOutput($sformatf("walk1 frame_start c%0d", c), 64'(frame_start),
                        64'((c == 0) || (c == 12)));
            if (c < 12) waitClocks(1);
        end
        waitClocks(3);
        checkOutput("walk1 step1 again", 64'(pins), 64'h2);

        // Dropping en mid-frame clears pins on the next clock; idle tracks mode.
        applyStimulus(1'b0, 3'd0, 1);
        checkOutput("en drop pins", 64'(pins), 64'h0);
        checkOutput("en drop frame_start", 64'(frame_start), 64'h0);
        applyStimulus(1'b0, 3'd3, 1);
        checkOutput("idle cur_mode 3", 64'(cur_mode), 64'h3);
        applyStimulus(1'b0, 3'd6, 1);
        checkOutput("idle mode6 maps to 0", 64'(cur_mode), 64'h0);
        applyStimulus(1'b1, 3'd6, 1);
        checkOutput("reenable frame_start", 64'(frame_start), 64'h1);
        checkOutput("reenable pins", 64'(pins), 64'h1);
        checkOutput("reenable cur_mode", 64'(cur_mode), 64'h0);
        waitClocks(1);
        checkOutput("reenable frame_start one clock", 64'(frame_start), 64'h0);

        // Pin-ID frame of 2*4+2 = 10 steps.
        applyStimulus(1'b0, 3'd4, 1);
        applyStimulus(1'b1, 3'd4, 1);
        checkOutput("pin_id cur_mode", 64'(cur_mode), 64'h4);
        pulses_pin3 = 0;
        pulses_pin0 = 0;
        for (int s = 0; s < 10; s++) begin
            checkOutput($sformatf("pin_id pins s%0d", s), 64'(pins), 64'(pin_id_exp[s]));
            checkOutput($sformatf("pin_id frame_start s%0d", s), 64'(frame_start), 64'(s == 0));
            pulses_pin3 += int'(pins[3]);
            pulses_pin0 += int'(pins[0]);
            waitClocks(3);
        end
        checkOutput("pin_id pin3 pulses", 64'(pulses_pin3), 64'd4);
        checkOutput("pin_id pin0 pulses", 64'(pulses_pin0), 64'd1);
        checkOutput("pin_id wrap frame_start", 64'(frame_start), 64'h1);
        checkOutput("pin_id wrap pins", 64'(pins), 64'hf);

        // Asynchronous reset in the middle of a step, then restart with en held.
        waitClocks(2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset pins", 64'(pins), 64'h0);
        checkOutput("async reset frame_start", 64'(frame_start), 64'h0);
        checkOutput("async reset cur_mode", 64'(cur_mode), 64'h0);
        waitClocks(1);
        reset = 1'b0;
        checkOutput("reset release pins", 64'(pins), 64'h0);
        waitClocks(1);
        checkOutput("post reset frame_start", 64'(frame_start), 64'h1);
        checkOutput("post reset pins", 64'(pins), 64'hf);
        checkOutput("post reset cur_mode", 64'(cur_mode), 64'h4);

        // Walk-zero with a toggle request at step 1: applied only at the frame wrap.
        applyStimulus(1'b0, 3'd1, 1);
        applyStimulus(1'b1, 3'd1, 1);
        checkOutput("walk0 s0 pins", 64'(pins), 64'he);
        checkOutput("walk0 s0 cur_mode", 64'(cur_mode), 64'h1);
        waitClocks(3);
        checkOutput("walk0 s1 pins", 64'(pins), 64'hd);
        applyStimulus(1'b1, 3'd3, 3);
        checkOutput("walk0 s2 pins", 64'(pins), 64'hb);
        checkOutput("walk0 s2 cur_mode", 64'(cur_mode), 64'h1);
        waitClocks(3);
        checkOutput("walk0 s3 pins", 64'(pins), 64'h7);
        checkOutput("walk0 s3 frame_start", 64'(frame_start), 64'h0);
        waitClocks(3);
        checkOutput("toggle s0 pins", 64'(pins), 64'hf);
        checkOutput("toggle s0 frame_start", 64'(frame_start), 64'h1);
        checkOutput("toggle s0 cur_mode", 64'(cur_mode), 64'h3);
        waitClocks(3);
        checkOutput("toggle s1 pins", 64'(pins), 64'h0);

        // en falls on the wrap tick: idle wins, no new frame.
        waitClocks(2);
        applyStimulus(1'b0, 3'd3, 1);
        checkOutput("en low at wrap pins", 64'(pins), 64'h0);
        checkOutput("en low at wrap frame_start", 64'(frame_start), 64'h0);

        // Count mode at DIV=1: 0..15 wrapping, frame_start every 256 clocks.
        mode_fast = 3'd2;
        en_fast   = 1'b1;
        waitClocks(1);
        checkOutput("count cur_mode", 64'(cur_mode_fast), 64'h2);
        for (int c = 0; c <= 257; c++) begin
            checkOutput($sformatf("count pins c%0d", c), 64'(pins_fast), 64'(c % 16));
            checkOutput($sformatf("count frame_start c%0d", c), 64'(frame_start_fast),
                        64'((c == 0) || (c == 256)));
            waitClocks(1);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
